// File: rtl/mod_shiftreg_stream_ctrl.sv
// Word-serial transfer controller between a 32-bit valid/ready stream and the
// serial port of a 2048-bit modular shift register (64 words, LS word first).
module mod_shiftreg_stream_ctrl #(
    parameter int W       = 32,
    parameter int N_WORDS = 64,
    parameter int CNT_W   = 7
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iStartWr,
    input  logic             iStartRd,
    input  logic             iAbort,
    input  logic [W-1:0]     iS_Data,
    input  logic             iS_Valid,
    output logic             oS_Ready,
    output logic [W-1:0]     oM_Data,
    output logic             oM_Valid,
    input  logic             iM_Ready,
    input  logic [W-1:0]     iSrData,
    output logic             oSrEnable,
    output logic [W-1:0]     oSrData,
    output logic             oBusy,
    output logic             oDone,
    output logic [CNT_W-1:0] oWordCnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last;

    assign w_last   = (r_cnt == CNT_W'(N_WORDS - 1));
    assign oWordCnt = r_cnt;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default before the
        // case so no path leaves one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        oS_Ready    = 1'b0;
        oM_Valid    = 1'b0;
        oM_Data     = '0;
        oSrEnable   = 1'b0;
        oSrData     = '0;
        oBusy       = 1'b0;
        oDone       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (iStartWr) begin
                    w_state_nxt = ST_WRITE;
                    w_cnt_nxt   = '0;
                end else if (iStartRd) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = '0;
                end
            end

            ST_WRITE: begin
                oS_Ready = 1'b1;
                oBusy    = 1'b1;
                if (iS_Valid) begin
                    oSrEnable = 1'b1;
                    oSrData   = iS_Data;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                end
                // Abort still lets a same-cycle handshake shift, but drops the count.
                if (iAbort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_READ: begin
                oM_Valid = 1'b1;
                oM_Data  = iSrData;
                oBusy    = 1'b1;
                if (iM_Ready) begin
                    // Rotate the outgoing word back into the top: reads are non-destructive.
                    oSrEnable = 1'b1;
                    oSrData   = iSrData;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = ST_DONE;
                end
                if (iAbort) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_DONE: begin
                oBusy       = 1'b1;
                oDone       = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_shiftreg_stream_ctrl.sv
// Bench for mod_shiftreg_stream_ctrl: queue-level register model, scoreboard
// queues filled by the stimulus tasks and drained by a negedge monitor.
`timescale 1ns/1ps
module tb_mod_shiftreg_stream_ctrl;

    localparam int W       = 32;
    localparam int N_WORDS = 64;
    localparam int CNT_W   = 7;

    logic             iClk = 1'b0;
    logic             iReset;
    logic             iStartWr;
    logic             iStartRd;
    logic             iAbort;
    logic [W-1:0]     iS_Data;
    logic             iS_Valid;
    logic             oS_Ready;
    logic [W-1:0]     oM_Data;
    logic             oM_Valid;
    logic             iM_Ready;
    logic [W-1:0]     iSrData;
    logic             oSrEnable;
    logic [W-1:0]     oSrData;
    logic             oBusy;
    logic             oDone;
    logic [CNT_W-1:0] oWordCnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_shifts = 0;
    int n_done   = 0;
    int exp_done = 0;

    // Physical shift register the controller drives (not reset by iReset).
    logic [W-1:0] sr [N_WORDS];
    // Reference contents, word0 first, updated per transfer at queue level.
    logic [W-1:0] ref_q [$];
    logic [W-1:0] exp_wr [$];
    logic [W-1:0] exp_rd [$];

    always #5 iClk = ~iClk;

    mod_shiftreg_stream_ctrl #(
        .W(W), .N_WORDS(N_WORDS), .CNT_W(CNT_W)
    ) dut (
        .iClk(iClk), .iReset(iReset), .iStartWr(iStartWr), .iStartRd(iStartRd),
        .iAbort(iAbort), .iS_Data(iS_Data), .iS_Valid(iS_Valid), .oS_Ready(oS_Ready),
        .oM_Data(oM_Data), .oM_Valid(oM_Valid), .iM_Ready(iM_Ready), .iSrData(iSrData),
        .oSrEnable(oSrEnable), .oSrData(oSrData), .oBusy(oBusy), .oDone(oDone),
        .oWordCnt(oWordCnt)
    );

    assign iSrData = sr[0];

    always @(posedge iClk) begin
        if (oSrEnable) begin
            for (int i = 0; i < N_WORDS - 1; i++) sr[i] <= sr[i+1];
            sr[N_WORDS-1] <= oSrData;
            n_shifts      <= n_shifts + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake seen mid-cycle.
    always @(negedge iClk) begin : monitor
        logic         wr_hs;
        logic         rd_hs;
        logic [W-1:0] w;
        wr_hs = oS_Ready && iS_Valid;
        rd_hs = oM_Valid && iM_Ready;
        if (oDone) n_done++;
        if (wr_hs) begin
            if (exp_wr.size() == 0) check("wr_unexpected_hs", 64'(1), 64'(0));
            else begin
                w = exp_wr.pop_front();
                check("wr_sr_data", 64'(oSrData), 64'(w));
            end
            check("wr_sr_enable", 64'(oSrEnable), 64'(1));
        end else if (rd_hs) begin
            if (exp_rd.size() == 0) check("rd_unexpected_hs", 64'(1), 64'(0));
            else begin
                w = exp_rd.pop_front();
                check("rd_m_data", 64'(oM_Data), 64'(w));
                check("rd_rotate_data", 64'(oSrData), 64'(w));
            end
            check("rd_sr_enable", 64'(oSrEnable), 64'(1));
        end else begin
            check("no_spurious_shift", 64'(oSrEnable), 64'(0));
        end
        if (!oM_Valid) check("m_data_idle_zero", 64'(oM_Data), 64'(0));
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic start(input bit wr, input bit rd);
        iStartWr = wr;
        iStartRd = rd;
        tick();
        iStartWr = 1'b0;
        iStartRd = 1'b0;
        check("start_busy", 64'(oBusy), 64'(1));
        check("start_cnt_zero", 64'(oWordCnt), 64'(0));
    endtask

    // Streams n words in; counting selects data 1..n, else random words.
    task automatic send_words(input int n, input bit bp, input bit counting);
        logic [W-1:0] w;
        int           guard;
        bit           hs;
        for (int i = 0; i < n; i++) begin
            w = counting ? W'(i + 1) : W'($urandom);
            exp_wr.push_back(w);
            void'(ref_q.pop_front());
            ref_q.push_back(w);
            iS_Data = w;
            guard   = 0;
            do begin
                iS_Valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge iClk);
                hs = iS_Valid && oS_Ready;
                tick();
                guard++;
            end while (!hs && guard < 200);
            if (!hs) begin
                check("wr_timeout", 64'(0), 64'(1));
                break;
            end
        end
        iS_Valid = 1'b0;
    endtask

    task automatic recv_words(input int n, input bit bp);
        int cnt;
        int guard;
        for (int i = 0; i < n; i++) exp_rd.push_back(ref_q[i]);
        for (int i = 0; i < n; i++) ref_q.push_back(ref_q.pop_front());
        cnt   = 0;
        guard = 0;
        while (cnt < n && guard < 1000) begin
            iM_Ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge iClk);
            if (iM_Ready && oM_Valid) cnt++;
            tick();
            guard++;
        end
        if (cnt < n) check("rd_timeout", 64'(cnt), 64'(n));
        iM_Ready = 1'b0;
    endtask

    task automatic finish_check();
        check("done_pulse", 64'(oDone), 64'(1));
        check("done_busy", 64'(oBusy), 64'(1));
        check("done_cnt", 64'(oWordCnt), 64'(N_WORDS));
        check("done_no_stream", 64'({oS_Ready, oM_Valid}), 64'(0));
        exp_done++;
        tick();
        check("done_one_cycle", 64'(oDone), 64'(0));
        check("idle_not_busy", 64'(oBusy), 64'(0));
        check("cnt_held", 64'(oWordCnt), 64'(N_WORDS));
        check("done_count", 64'(n_done), 64'(exp_done));
    endtask

    task automatic cmp_reg(input string tag);
        for (int i = 0; i < N_WORDS; i++)
            if (sr[i] !== ref_q[i]) check({tag, "_reg_word"}, 64'(sr[i]), 64'(ref_q[i]));
        check({tag, "_reg_ok"}, 64'(sr[0]), 64'(ref_q[0]));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int           s0;
        logic [W-1:0] w;
        iReset = 1'b1; iStartWr = 1'b0; iStartRd = 1'b0; iAbort = 1'b0;
        iS_Data = '0; iS_Valid = 1'b0; iM_Ready = 1'b0;
        for (int i = 0; i < N_WORDS; i++) begin
            w = W'($urandom);
            ref_q.push_back(w);
            sr[i] <= w;
        end

        #22;
        check("rst_flags", 64'({oS_Ready, oM_Valid, oSrEnable, oBusy, oDone}), 64'(0));
        check("rst_sr_data", 64'(oSrData), 64'(0));
        check("rst_m_data", 64'(oM_Data), 64'(0));
        check("rst_cnt", 64'(oWordCnt), 64'(0));
        @(negedge iClk);
        iReset = 1'b0;
        tick();
        check("idle_after_rst", 64'(oBusy), 64'(0));

        // Back-to-back write of 1..64.
        s0 = n_shifts;
        start(1, 0);
        send_words(N_WORDS, 0, 1);
        check("wr_shift_count", 64'(n_shifts - s0), 64'(N_WORDS));
        finish_check();
        check("reg_word0", 64'(sr[0]), 64'(32'h1));
        check("reg_word63", 64'(sr[N_WORDS-1]), 64'(32'h40));
        cmp_reg("wr");

        // Two continuous reads: identical sequences, rotation preserved.
        repeat (2) begin
            s0 = n_shifts;
            start(0, 1);
            recv_words(N_WORDS, 0);
            check("rd_shift_count", 64'(n_shifts - s0), 64'(N_WORDS));
            finish_check();
            cmp_reg("rd");
        end

        // Random backpressure on both directions.
        s0 = n_shifts;
        start(1, 0);
        send_words(N_WORDS, 1, 0);
        check("bp_wr_shift_count", 64'(n_shifts - s0), 64'(N_WORDS));
        finish_check();
        s0 = n_shifts;
        start(0, 1);
        recv_words(N_WORDS, 1);
        check("bp_rd_shift_count", 64'(n_shifts - s0), 64'(N_WORDS));
        finish_check();
        cmp_reg("bp");

        // Simultaneous start: write wins.
        s0 = n_shifts;
        start(1, 1);
        check("both_start_s_ready", 64'(oS_Ready), 64'(1));
        check("both_start_m_valid", 64'(oM_Valid), 64'(0));
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("both_abort_idle", 64'(oBusy), 64'(0));
        check("both_no_shift", 64'(n_shifts - s0), 64'(0));

        // Abort at count 20 with no handshake.
        s0 = n_shifts;
        start(1, 0);
        send_words(20, 0, 1);
        check("abort_cnt20", 64'(oWordCnt), 64'(20));
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("abort_busy", 64'(oBusy), 64'(0));
        check("abort_cnt", 64'(oWordCnt), 64'(0));
        check("abort_shifts", 64'(n_shifts - s0), 64'(20));
        tick();
        check("abort_no_done", 64'(n_done), 64'(exp_done));
        cmp_reg("abort");

        // Abort with a handshake in the same cycle: one final shift.
        s0 = n_shifts;
        start(1, 0);
        send_words(5, 0, 0);
        w = W'($urandom);
        exp_wr.push_back(w);
        void'(ref_q.pop_front());
        ref_q.push_back(w);
        iS_Data = w; iS_Valid = 1'b1; iAbort = 1'b1;
        tick();
        iS_Valid = 1'b0; iAbort = 1'b0;
        check("abort_hs_shifts", 64'(n_shifts - s0), 64'(6));
        check("abort_hs_busy", 64'(oBusy), 64'(0));
        check("abort_hs_cnt", 64'(oWordCnt), 64'(0));
        cmp_reg("abort_hs");

        // Asynchronous reset in the middle of a read at word 10.
        start(0, 1);
        recv_words(10, 0);
        check("rd_cnt10", 64'(oWordCnt), 64'(10));
        iM_Ready = 1'b1;
        #2;
        iReset = 1'b1;
        #1;
        check("arst_flags", 64'({oM_Valid, oSrEnable, oBusy}), 64'(0));
        check("arst_cnt", 64'(oWordCnt), 64'(0));
        iM_Ready = 1'b0;
        @(negedge iClk);
        iReset = 1'b0;
        tick();
        check("arst_idle", 64'(oBusy), 64'(0));
        s0 = n_shifts;
        start(0, 1);
        recv_words(N_WORDS, 0);
        check("arst_rd_shift_count", 64'(n_shifts - s0), 64'(N_WORDS));
        finish_check();
        cmp_reg("arst");

        check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
